// File: rtl/ifft_cp_inserter.sv
// Frame buffer behind the IFFT: collects N samples, then replays the last CP_LEN samples followed by the whole frame.
// Optional frame/resync counters are enabled with `define IFFT_CP_FRAME_CNT_EN.
module ifft_cp_inserter #(
  parameter int N      = 4,
  parameter int CP_LEN = 1,
  parameter int W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sop,
  input  logic [W-1:0] in_real,
  input  logic [W-1:0] in_imag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_real,
  output logic [W-1:0] out_imag,
  output logic         out_sop,
  output logic         out_last,
  output logic         err_sync
`ifdef IFFT_CP_FRAME_CNT_EN
  ,
  output logic [15:0]  frame_cnt,
  output logic [7:0]   sync_err_cnt
`endif
);
  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST     = PW'(N - 1);
  localparam logic [PW-1:0] CP_START = PW'(N - CP_LEN);

  typedef enum logic [1:0] {FILL, EMIT_CP, EMIT_BODY} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          first_q, first_d;
  logic          err_sync_q, err_sync_d;

  logic [W-1:0]  mem_re [N];
  logic [W-1:0]  mem_im [N];

  logic          accept, xfer, resync;
  logic [PW-1:0] wr_addr;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q != FILL);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign resync    = accept & in_sop & (wr_ptr_q != '0);
  assign wr_addr   = resync ? '0 : wr_ptr_q;

  assign out_real  = mem_re[rd_ptr_q];
  assign out_imag  = mem_im[rd_ptr_q];
  assign out_sop   = out_valid & first_q;
  assign out_last  = (state_q == EMIT_BODY) && (rd_ptr_q == LAST);
  assign err_sync  = err_sync_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    first_d    = first_q;
    err_sync_d = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (resync) begin
            // a new frame start mid-fill restarts the frame at mem[0]
            wr_ptr_d   = PW'(1);
            err_sync_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (wr_ptr_q == LAST) begin
              first_d = 1'b1;
              if (CP_LEN == 0) begin
                state_d  = EMIT_BODY;
                rd_ptr_d = '0;
              end else begin
                state_d  = EMIT_CP;
                rd_ptr_d = CP_START;
              end
            end
          end
        end
      end
      EMIT_CP: begin
        if (xfer) begin
          first_d  = 1'b0;
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (rd_ptr_q == LAST) state_d = EMIT_BODY;
        end
      end
      EMIT_BODY: begin
        if (xfer) begin
          first_d  = 1'b0;
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (rd_ptr_q == LAST) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      first_q    <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      first_q    <= first_d;
      err_sync_q <= err_sync_d;
    end
  end

  // buffer survives reset; only the pointers are cleared
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      mem_re[wr_addr] <= in_real;
      mem_im[wr_addr] <= in_imag;
    end
  end

`ifdef IFFT_CP_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  sync_err_cnt_q, sync_err_cnt_d;

  always_comb begin
    frame_cnt_d    = frame_cnt_q + ((xfer && out_last) ? 16'd1 : 16'd0);
    sync_err_cnt_d = sync_err_cnt_q;
    if (err_sync_q && sync_err_cnt_q != 8'hFF) sync_err_cnt_d = sync_err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt_q    <= '0;
      sync_err_cnt_q <= '0;
    end else begin
      frame_cnt_q    <= frame_cnt_d;
      sync_err_cnt_q <= sync_err_cnt_d;
    end
  end

  assign frame_cnt    = frame_cnt_q;
  assign sync_err_cnt = sync_err_cnt_q;
`endif
endmodule

// File: doc/ifft_cp_inserter.md
Name: ifft_cp_inserter

Overview:
- Downstream stage of the IFFT block in the OFDM transmit path.
- Collects one frame of N complex time-domain samples from the IFFT output.
- Replays the frame with a cyclic prefix: the last CP_LEN samples first, then all N samples in order.
- Uses valid/ready streaming on both sides and a single frame buffer, so input and output phases alternate.

Parameters:
- N, 4, IFFT frame length in samples; power of 2, at least 2.
- CP_LEN, 1, cyclic prefix length; 0 <= CP_LEN <= N-1. CP_LEN = 0 gives pass-through buffering.
- W, 16, signed sample width for each of real and imag.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample this cycle
- in_sop  input  1  first sample of an IFFT frame; qualified by in_valid
- in_real  input  W  signed real part
- in_imag  input  W  signed imag part
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accepts the sample
- out_real  output  W  signed real part
- out_imag  output  W  signed imag part
- out_sop  output  1  first beat of the frame (first CP sample, or body[0] if CP_LEN = 0)
- out_last  output  1  last beat of the frame (body[N-1])
- err_sync  output  1  one-cycle pulse on a frame resynchronisation

Behaviour:
- Storage and pointers:
  - Buffer mem[0..N-1] holds real and imag, W bits each.
  - Pointers wr_ptr and rd_ptr are each clog2(N) bits.
  - States: FILL, EMIT_CP, EMIT_BODY.
- Reset (reset == 0 at a clock edge):
  - state = FILL, wr_ptr = 0, rd_ptr = 0.
  - in_ready = 1; out_valid, out_sop, out_last, err_sync = 0.
  - out_real and out_imag read mem[0]; their value is don't-care while out_valid = 0.
  - Buffer contents are not cleared.
  - Reset mid-frame abandons the frame; no partial output is produced.
- FILL state:
  - in_ready = 1 and out_valid = 0.
  - An accept is in_valid & in_ready: write mem[wr_ptr] and increment wr_ptr.
  - Accept with wr_ptr == N-1: wr_ptr wraps to 0. Next state is EMIT_CP with rd_ptr = N-CP_LEN, or EMIT_BODY with rd_ptr = 0 if CP_LEN == 0.
- Resync:
  - An accept with in_sop = 1 while wr_ptr != 0 writes mem[0], sets wr_ptr = 1 and pulses err_sync for the next cycle.
  - in_sop = 1 with wr_ptr == 0 is normal operation.
  - in_sop = 0 with wr_ptr == 0 is accepted as frame start; no error.
- EMIT_CP and EMIT_BODY states:
  - in_ready = 0 and out_valid = 1.
  - out_real/out_imag = mem[rd_ptr], a combinational buffer read.
  - Output data stays stable while out_valid & !out_ready.
  - A transfer is out_valid & out_ready, and increments rd_ptr.
- EMIT_CP exit: transfer with rd_ptr == N-1 sets rd_ptr = 0 and moves to EMIT_BODY.
- EMIT_BODY exit: transfer with rd_ptr == N-1 sets rd_ptr = 0 and returns to FILL. in_ready goes high the following cycle.
- Flags:
  - out_sop = 1 on the first beat of EMIT_CP, or on the first beat of EMIT_BODY when CP_LEN = 0. Use a first-beat flag: it is set on entry to the emit phase and cleared on the first transfer.
  - out_last = 1 in EMIT_BODY with rd_ptr == N-1.
  - Both flags are held during stall.
- Latency and throughput:
  - out_valid asserts the cycle after the N-th accept.
  - One frame costs N input cycles plus N+CP_LEN output transfers; no overlap.
- Arithmetic: samples are passed unmodified; no scaling and no sign change.
- in_valid while in_ready = 0 is ignored; the upstream must hold the sample.

Optional Feature:
- Macro: IFFT_CP_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt, 16 bits, reset to 0.
  - Increments on each out_last transfer and wraps 0xFFFF -> 0.
  - Also adds output port sync_err_cnt, 8 bits, reset to 0. It increments on each err_sync pulse and saturates at 0xFF.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Basic frame (N=4, CP_LEN=1, out_ready=1): feed real 1,2,3,4 with imag 10,20,30,40 and in_sop on the first sample.
  - Required output: (4,40),(1,10),(2,20),(3,30),(4,40).
  - out_sop on beat 0, out_last on beat 4.
  - out_valid first high the cycle after sample 4 is accepted.
- Backpressure: same frame with out_ready toggling 1,0,0,1,... -> identical 5-beat sequence, data and flags stable during stalls, in_ready = 0 throughout emission.
- Back-to-back frames: frames A (1..4) and B (-1..-4) offered continuously.
  - Required output: 4,1,2,3,4 then -4,-1,-2,-3,-4.
  - in_ready returns to 1 exactly one cycle after A's out_last transfer.
- Resync: accept 1,2, then 7 with in_sop=1, then 8,9,10.
  - err_sync pulses once.
  - Output is 10,7,8,9,10.
- Reset mid-emit: assert reset=0 for one cycle after 2 output beats.
  - out_valid = 0 and in_ready = 1 the cycle after reset.
  - The next frame 5,6,7,8 outputs 8,5,6,7,8.
- CP_LEN=0 build plus IFFT_CP_FRAME_CNT_EN: two frames -> each outputs 4 beats in order with out_sop on body[0]; frame_cnt = 2 afterwards.
